core_issue_ctrl: RTL
====================

Name: core_issue_ctrl

Overview:
Issue scheduler between the instruction decoder and the execute units of the RV32I+F core. It holds a 32-entry register scoreboard and stalls decoded instructions on RAW/WAW hazards. It also arbitrates the single non-pipelined long-latency unit (FDIV/FSQRT) and counts stall cycles for performance monitoring.

Parameters:
LONG_LAT, 16, cycles the long unit stays occupied per operation (>=2)
CNT_W, 16, width of saturating stall counter

Ports:
CLK  in  1  clock
RST_N  in  1  reset
DEC_VALID  in  1  decoded instruction present
DEC_RD  in  5  destination register number
DEC_RS1  in  5  source 1 register number (0 = unused)
DEC_RS2  in  5  source 2 register number (0 = unused)
DEC_WR_RD  in  1  instruction writes DEC_RD
DEC_LONG  in  1  instruction needs the long unit
FLUSH  in  1  branch/jump redirect; kill the current decode slot
WB_VALID  in  1  writeback completes this cycle
WB_RD  in  5  writeback register number
DEC_READY  out  1  combinational; instruction accepted this cycle
ISSUE_VALID  out  1  registered issue pulse to execute
ISSUE_RD  out  5  registered rd of issued instruction (0 if DEC_WR_RD=0)
ISSUE_LONG  out  1  registered; issued instruction uses long unit
LONG_BUSY  out  1  long unit occupied
SB_BUSY  out  32  scoreboard busy bits, bit n = register n
STALL_CNT  out  CNT_W  saturating count of hazard stall cycles

Behaviour:
- Reset: RST_N is synchronous and active-low; clock is CLK. All outputs, scoreboard, FSM and counters go to 0 and the FSM goes to IDLE. Reset mid long-op aborts the op. Pending busy bits are dropped.
- busy_eff[n] = SB_BUSY[n] & ~(WB_VALID & WB_RD==n). A same-cycle writeback clears the hazard with no extra stall. busy_eff[0] is always 0.
- hazard = busy_eff[RS1] | busy_eff[RS2] | (DEC_WR_RD & busy_eff[RD]) (WAW) | (DEC_LONG & LONG_BUSY).
- DEC_READY = DEC_VALID & ~FLUSH & ~hazard. The decode stage holds its instruction stable while DEC_READY=0.
- Issue registers, updated every cycle:
  - ISSUE_VALID <= DEC_READY.
  - ISSUE_RD <= DEC_READY & DEC_WR_RD ? DEC_RD : 0.
  - ISSUE_LONG <= DEC_READY & DEC_LONG.
  - Latency from decode to issue pulse is 1 cycle.
- Scoreboard next state:
  - Step 1: clear bit WB_RD if WB_VALID.
  - Step 2: set bit DEC_RD if DEC_READY & DEC_WR_RD & DEC_RD!=0.
  - If both target the same register in one cycle, the set wins.
  - Bit 0 is never set.
  - A WB_VALID to a non-busy register is ignored; no error is raised.
- Long-unit FSM:
  - IDLE: on DEC_READY & DEC_LONG, load cnt = LONG_LAT-1 and go to RUN.
  - RUN: decrement cnt each cycle. When cnt==0, go to IDLE.
  - LONG_BUSY = (state==RUN). It is high for exactly LONG_LAT cycles, starting the cycle after issue.
  - A second long op can issue the same cycle the FSM returns to IDLE.
  - The long unit's result writeback still arrives via WB_VALID/WB_RD. The FSM tracks only structural occupancy.
- FLUSH:
  - Suppresses issue in the cycle it is high; ISSUE_VALID=0 next cycle.
  - Does not alter the scoreboard or the long FSM, because in-flight writes still complete.
  - Does not count as a stall.
- STALL_CNT increments when DEC_VALID & ~FLUSH & hazard. It saturates at all-ones with no wrap.
- DEC_VALID=0: no issue, no stall count, scoreboard still processes WB.

Test Plan:
- RAW stall: issue rd=5 (WR_RD=1) -> SB_BUSY[5]=1. Next op RS1=5 -> DEC_READY=0 and STALL_CNT increments each cycle. WB_VALID with WB_RD=5 -> DEC_READY=1 in that same cycle and ISSUE_VALID=1 in the next cycle.
- Same-cycle writeback plus reissue: SB_BUSY[7]=1, WB_RD=7 while decoding RD=7 with WR_RD=1 -> issue accepted and SB_BUSY[7] stays 1 (set wins).
- x0: RD=0 with WR_RD=1 -> SB_BUSY[0] stays 0 and ISSUE_RD=0. A following RS1=0 -> no stall.
- Long unit with LONG_LAT=16: issue a long op -> LONG_BUSY high for exactly 16 cycles. A second long op presented immediately stalls 16 cycles and then issues. An independent short op issues meanwhile without stall.
- Flush: FLUSH=1 with a hazard-free DEC_VALID -> DEC_READY=0, ISSUE_VALID=0, STALL_CNT unchanged, SB_BUSY unchanged.
- Saturation and reset: force more than 2^16 stall cycles -> STALL_CNT=16'hFFFF. Assert RST_N=0 during LONG_BUSY -> next cycle LONG_BUSY=0, SB_BUSY=0, STALL_CNT=0.

Source files
------------

// File: rtl/core_issue_ctrl.sv
// rtl/core_issue_ctrl.sv - issue scheduler with register scoreboard, long-unit arbiter and stall counter
module core_issue_ctrl #(
  parameter int LONG_LAT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             DEC_VALID,
  input  logic [4:0]       DEC_RD,
  input  logic [4:0]       DEC_RS1,
  input  logic [4:0]       DEC_RS2,
  input  logic             DEC_WR_RD,
  input  logic             DEC_LONG,
  input  logic             FLUSH,
  input  logic             WB_VALID,
  input  logic [4:0]       WB_RD,
  output logic             DEC_READY,
  output logic             ISSUE_VALID,
  output logic [4:0]       ISSUE_RD,
  output logic             ISSUE_LONG,
  output logic             LONG_BUSY,
  output logic [31:0]      SB_BUSY,
  output logic [CNT_W-1:0] STALL_CNT
);

  localparam int CW = (LONG_LAT > 2) ? $clog2(LONG_LAT) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   busy_eff;
  logic [31:0]   sb_next;
  logic          hazard;

  // Scoreboard view seen by decode: a writeback landing this cycle already frees its register
  always_comb begin
    busy_eff = SB_BUSY;
    if (WB_VALID) begin
      busy_eff[WB_RD] = 1'b0;
    end
    busy_eff[0] = 1'b0;
  end

  assign hazard = busy_eff[DEC_RS1] | busy_eff[DEC_RS2] |
                  (DEC_WR_RD & busy_eff[DEC_RD]) |
                  (DEC_LONG & LONG_BUSY);

  assign DEC_READY = DEC_VALID & ~FLUSH & ~hazard;
  assign LONG_BUSY = (state == RUN);

  // Next scoreboard: writeback clears first, then an accepted writer sets, so a same-register set wins
  always_comb begin
    sb_next = SB_BUSY;
    if (WB_VALID) begin
      sb_next[WB_RD] = 1'b0;
    end
    if (DEC_READY && DEC_WR_RD && (DEC_RD != 5'd0)) begin
      sb_next[DEC_RD] = 1'b1;
    end
    sb_next[0] = 1'b0;
  end

  // Issue pulse registers and scoreboard state
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ISSUE_VALID <= 1'b0;
      ISSUE_RD    <= 5'd0;
      ISSUE_LONG  <= 1'b0;
      SB_BUSY     <= 32'd0;
    end else begin
      ISSUE_VALID <= DEC_READY;
      ISSUE_RD    <= (DEC_READY && DEC_WR_RD) ? DEC_RD : 5'd0;
      ISSUE_LONG  <= DEC_READY & DEC_LONG;
      SB_BUSY     <= sb_next;
    end
  end

  // Long-unit occupancy FSM: RUN lasts exactly LONG_LAT cycles after a long issue
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (DEC_READY && DEC_LONG) begin
            state <= RUN;
            cnt   <= CW'(LONG_LAT - 1);
          end
        end
        RUN: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Saturating count of cycles a live instruction is held back by a hazard
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      STALL_CNT <= '0;
    end else if (DEC_VALID && !FLUSH && hazard && (STALL_CNT != {CNT_W{1'b1}})) begin
      STALL_CNT <= STALL_CNT + CNT_W'(1);
    end
  end

endmodule
